pc_unit: RTL and testbench

- Parametrised program-counter generator for the DLX pipeline front end; drives the fetch address into IF.
- Replaces a fixed 32-bit PC that could only count up by 4 or load a new address.
- Adds the following:
  - configurable width, step and reset/trap vectors;
  - a fetch handshake and stall hold;
  - prioritised redirect sources;
  - misalignment trapping;
  - a circular return-address stack (RAS) for call/return prediction.

---
 rtl/pc_unit.sv | 140 ++++++++++++++
 tb/tb_pc_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter generator for the DLX fetch stage: sequential stepping, stall hold,
// prioritised trap/redirect/return sources and a circular return-address stack.
module pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           fetch_ready,
  input  logic                           stall,
  input  logic                           trap,
  input  logic                           redirect,
  input  logic [WIDTH-1:0]               redirect_target,
  input  logic                           ras_push,
  input  logic [WIDTH-1:0]               ras_push_addr,
  input  logic                           ras_pop,
  output logic [WIDTH-1:0]               pc_out,
  output logic                           pc_valid,
  output logic                           misalign,
  output logic                           ras_underflow,
  output logic [$clog2(RAS_DEPTH):0]     ras_count
);

  localparam int unsigned      PW         = $clog2(RAS_DEPTH);
  localparam int unsigned      CW         = PW + 1;
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);
  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  localparam logic [CW-1:0]    FULL       = CW'(RAS_DEPTH);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] pc_r, pc_nxt_s;
  logic             valid_r, misalign_r, misalign_nxt_s, underflow_r, underflow_nxt_s;
  logic [PW-1:0]    ptr_r, ptr_nxt_s, wr_idx_s;
  logic [CW-1:0]    count_r, count_nxt_s;
  logic             wr_en_s, pop_ok_s, misaligned_s;
  logic [WIDTH-1:0] top_s;
  logic [WIDTH-1:0] ras_mem_r [RAS_DEPTH];

  assign pop_ok_s     = ras_pop && (count_r != {CW{1'b0}});
  assign misaligned_s = (redirect_target & ALIGN_MASK) != {WIDTH{1'b0}};
  assign top_s        = ras_mem_r[ptr_r];

  // Next-state, next-PC and return-stack update selection
  always_comb begin
    state_nxt_s     = state_r;
    pc_nxt_s        = pc_r;
    misalign_nxt_s  = 1'b0;
    underflow_nxt_s = 1'b0;
    ptr_nxt_s       = ptr_r;
    count_nxt_s     = count_r;
    wr_en_s         = 1'b0;
    wr_idx_s        = ptr_r;
    case (state_r)
      BOOT: state_nxt_s = RUN;
      RUN: begin
        if (trap) begin
          pc_nxt_s = TRAP_VECTOR;
        end else if (redirect && misaligned_s) begin
          pc_nxt_s       = TRAP_VECTOR;
          misalign_nxt_s = 1'b1;
        end else if (redirect) begin
          pc_nxt_s = redirect_target;
        end else if (pop_ok_s) begin
          pc_nxt_s = top_s;
        end else if (stall || !fetch_ready) begin
          pc_nxt_s = pc_r;
        end else begin
          pc_nxt_s = pc_r + STEP_W;
        end

        // An empty-stack pop is flagged even when a higher source owns the PC
        if (ras_pop && !pop_ok_s) begin
          underflow_nxt_s = 1'b1;
        end else begin
          underflow_nxt_s = 1'b0;
        end

        case ({ras_push, pop_ok_s})
          2'b10: begin
            ptr_nxt_s   = ptr_r + PW'(1);
            wr_en_s     = 1'b1;
            wr_idx_s    = ptr_r + PW'(1);
            count_nxt_s = (count_r == FULL) ? count_r : count_r + CW'(1);
          end
          2'b01: begin
            ptr_nxt_s   = ptr_r - PW'(1);
            count_nxt_s = count_r - CW'(1);
          end
          2'b11: begin
            wr_en_s  = 1'b1;
            wr_idx_s = ptr_r;
          end
          default: begin
            wr_en_s = 1'b0;
          end
        endcase
      end
      default: state_nxt_s = BOOT;
    endcase
  end

  // State, PC, flag and return-stack registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= BOOT;
      pc_r        <= RESET_VECTOR;
      valid_r     <= 1'b0;
      misalign_r  <= 1'b0;
      underflow_r <= 1'b0;
      ptr_r       <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      state_r     <= state_nxt_s;
      pc_r        <= pc_nxt_s;
      valid_r     <= (state_nxt_s == RUN);
      misalign_r  <= misalign_nxt_s;
      underflow_r <= underflow_nxt_s;
      ptr_r       <= ptr_nxt_s;
      count_r     <= count_nxt_s;
      if (wr_en_s) begin
        ras_mem_r[wr_idx_s] <= ras_push_addr;
      end
    end
  end

  assign pc_out        = pc_r;
  assign pc_valid      = valid_r;
  assign misalign      = misalign_r;
  assign ras_underflow = underflow_r;
  assign ras_count     = count_r;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with default parameters.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_ready, stall, trap, redirect, ras_push, ras_pop;
  logic [31:0] redirect_target, ras_push_addr;
  logic [31:0] pc_out;
  logic        pc_valid, misalign, ras_underflow;
  logic [2:0]  ras_count;

  int n_cmp = 0;
  int n_bad = 0;

  pc_unit dut (
    .clk(clk), .reset(reset), .fetch_ready(fetch_ready), .stall(stall), .trap(trap),
    .redirect(redirect), .redirect_target(redirect_target), .ras_push(ras_push),
    .ras_push_addr(ras_push_addr), .ras_pop(ras_pop), .pc_out(pc_out), .pc_valid(pc_valid),
    .misalign(misalign), .ras_underflow(ras_underflow), .ras_count(ras_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_ready = 1'b1; stall = 1'b0; trap = 1'b0; redirect = 1'b0;
    redirect_target = 32'h0; ras_push = 1'b0; ras_push_addr = 32'h0; ras_pop = 1'b0;
  endtask

  task automatic goto_pc(input logic [31:0] a);
    redirect = 1'b1; redirect_target = a;
    tick();
    redirect = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_seq [3];
    exp_seq[0] = 32'h0; exp_seq[1] = 32'h4; exp_seq[2] = 32'h8;
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    n_cmp++;
    if (pc_out !== 32'h0 || pc_valid !== 1'b0 || ras_count !== 3'd0) begin
      $display("FAIL reset_state: pc=%h valid=%b cnt=%0d, want 0/0/0", pc_out, pc_valid, ras_count);
      n_bad++;
    end
    reset = 1'b0;
    trap = 1'b1; ras_push = 1'b1; ras_push_addr = 32'h44;
    tick();
    idle_inputs();
    n_cmp++;
    if (pc_out !== 32'h0 || pc_valid !== 1'b1 || ras_count !== 3'd0) begin
      $display("FAIL boot_ignores: pc=%h valid=%b cnt=%0d, want 0/1/0", pc_out, pc_valid, ras_count);
      n_bad++;
    end
    for (int i = 1; i <= 16; i++) tick();
    n_cmp++;
    if (pc_out !== 32'h40) begin
      $display("FAIL run_to_40: pc=%h, want 00000040", pc_out);
      n_bad++;
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (pc_out !== 32'h0 || pc_valid !== 1'b0) begin
      $display("FAIL async_reset: pc=%h valid=%b, want 0/0", pc_out, pc_valid);
      n_bad++;
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (pc_out !== exp_seq[i] || pc_valid !== 1'b1) begin
        $display("FAIL boot_seq[%0d]: pc=%h valid=%b, want %h/1", i, pc_out, pc_valid, exp_seq[i]);
        n_bad++;
      end
    end
  endtask

  task automatic test_stall();
    goto_pc(32'h10);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (pc_out !== 32'h10) begin
        $display("FAIL stall_hold[%0d]: pc=%h, want 00000010", i, pc_out);
        n_bad++;
      end
    end
    stall = 1'b0; fetch_ready = 1'b0;
    tick();
    n_cmp++;
    if (pc_out !== 32'h10) begin
      $display("FAIL not_ready_hold: pc=%h, want 00000010", pc_out);
      n_bad++;
    end
    fetch_ready = 1'b1;
    tick();
    n_cmp++;
    if (pc_out !== 32'h14) begin
      $display("FAIL resume_step: pc=%h, want 00000014", pc_out);
      n_bad++;
    end
  endtask

  task automatic test_priority();
    ras_push = 1'b1; ras_push_addr = 32'h200;
    goto_pc(32'h20);
    ras_push = 1'b0;
    n_cmp++;
    if (pc_out !== 32'h20 || ras_count !== 3'd1) begin
      $display("FAIL prio_setup: pc=%h cnt=%0d, want 00000020/1", pc_out, ras_count);
      n_bad++;
    end
    trap = 1'b1; redirect = 1'b1; redirect_target = 32'h80; ras_pop = 1'b1;
    tick();
    idle_inputs();
    n_cmp++;
    if (pc_out !== 32'h100 || ras_count !== 3'd0 || misalign !== 1'b0 || ras_underflow !== 1'b0) begin
      $display("FAIL trap_wins: pc=%h cnt=%0d mis=%b und=%b, want 00000100/0/0/0",
               pc_out, ras_count, misalign, ras_underflow);
      n_bad++;
    end
    goto_pc(32'h82);
    n_cmp++;
    if (pc_out !== 32'h100 || misalign !== 1'b1) begin
      $display("FAIL misalign_trap: pc=%h mis=%b, want 00000100/1", pc_out, misalign);
      n_bad++;
    end
    tick();
    n_cmp++;
    if (pc_out !== 32'h104 || misalign !== 1'b0) begin
      $display("FAIL misalign_pulse: pc=%h mis=%b, want 00000104/0", pc_out, misalign);
      n_bad++;
    end
  endtask

  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFC);
    n_cmp++;
    if (pc_out !== 32'hFFFF_FFFC) begin
      $display("FAIL wrap_setup: pc=%h, want fffffffc", pc_out);
      n_bad++;
    end
    tick();
    n_cmp++;
    if (pc_out !== 32'h0) begin
      $display("FAIL wrap: pc=%h, want 00000000", pc_out);
      n_bad++;
    end
  endtask

  task automatic test_ras_overflow();
    logic [2:0]  exp_cnt [5];
    logic [31:0] exp_pop [4];
    exp_cnt[0] = 3'd1; exp_cnt[1] = 3'd2; exp_cnt[2] = 3'd3; exp_cnt[3] = 3'd4; exp_cnt[4] = 3'd4;
    exp_pop[0] = 32'h50; exp_pop[1] = 32'h40; exp_pop[2] = 32'h30; exp_pop[3] = 32'h20;
    for (int i = 0; i < 5; i++) begin
      ras_push = 1'b1; ras_push_addr = 32'(16 * (i + 1));
      tick();
      n_cmp++;
      if (ras_count !== exp_cnt[i]) begin
        $display("FAIL push_count[%0d]: cnt=%0d, want %0d", i, ras_count, exp_cnt[i]);
        n_bad++;
      end
    end
    ras_push = 1'b0;
    ras_pop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (pc_out !== exp_pop[i] || ras_count !== 3'(3 - i) || ras_underflow !== 1'b0) begin
        $display("FAIL pop[%0d]: pc=%h cnt=%0d und=%b, want %h/%0d/0",
                 i, pc_out, ras_count, ras_underflow, exp_pop[i], 3 - i);
        n_bad++;
      end
    end
    tick();
    ras_pop = 1'b0;
    n_cmp++;
    if (pc_out !== 32'h24 || ras_count !== 3'd0 || ras_underflow !== 1'b1) begin
      $display("FAIL underflow: pc=%h cnt=%0d und=%b, want 00000024/0/1", pc_out, ras_count, ras_underflow);
      n_bad++;
    end
    tick();
    n_cmp++;
    if (pc_out !== 32'h28 || ras_underflow !== 1'b0) begin
      $display("FAIL underflow_pulse: pc=%h und=%b, want 00000028/0", pc_out, ras_underflow);
      n_bad++;
    end
  endtask

  task automatic test_push_pop();
    ras_push = 1'b1; ras_push_addr = 32'h10;
    tick();
    ras_push_addr = 32'h20;
    tick();
    ras_push_addr = 32'h99; ras_pop = 1'b1;
    tick();
    ras_push = 1'b0;
    n_cmp++;
    if (pc_out !== 32'h20 || ras_count !== 3'd2) begin
      $display("FAIL push_pop: pc=%h cnt=%0d, want 00000020/2", pc_out, ras_count);
      n_bad++;
    end
    tick();
    n_cmp++;
    if (pc_out !== 32'h99 || ras_count !== 3'd1) begin
      $display("FAIL pop_replaced: pc=%h cnt=%0d, want 00000099/1", pc_out, ras_count);
      n_bad++;
    end
    tick();
    ras_pop = 1'b0;
    n_cmp++;
    if (pc_out !== 32'h10 || ras_count !== 3'd0) begin
      $display("FAIL pop_bottom: pc=%h cnt=%0d, want 00000010/0", pc_out, ras_count);
      n_bad++;
    end
  endtask

  task automatic test_back_to_back();
    fetch_ready = 1'b0;
    goto_pc(32'h300);
    n_cmp++;
    if (pc_out !== 32'h300) begin
      $display("FAIL redirect_not_ready: pc=%h, want 00000300", pc_out);
      n_bad++;
    end
    goto_pc(32'h400);
    n_cmp++;
    if (pc_out !== 32'h400) begin
      $display("FAIL redirect_b2b: pc=%h, want 00000400", pc_out);
      n_bad++;
    end
    tick();
    fetch_ready = 1'b1;
    n_cmp++;
    if (pc_out !== 32'h400 || pc_valid !== 1'b1) begin
      $display("FAIL hold_after_redirect: pc=%h valid=%b, want 00000400/1", pc_out, pc_valid);
      n_bad++;
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_priority();
    test_wrap();
    test_ras_overflow();
    test_push_pop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
